// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared types and constants for the 2x2 wormhole router.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int NUM_PORTS = 2;
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TXN_W     = 4;

  // One flit as it travels between input FIFOs and output ports.
  typedef struct packed {
    logic              head;
    logic              tail;
    logic              valid;
    logic [31:0]       data;
    logic [PORT_W-1:0] output_port_num;
    logic [TXN_W-1:0]  txn_id;
  } pkt_flit_t;

  // Output-port arbiter states.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of idx in a ring of n entries.
  function automatic int unsigned next_rr_ptr(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first requester at
//            or after i_ptr (wrapping), as one-hot and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_upper_mask;
  logic [N-1:0] w_upper_req;
  logic [N-1:0] w_src;

  // Requests at or above the pointer get first chance.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign w_upper_mask[gi] = (IDX_W'(gi) >= i_ptr);
  end

  assign w_upper_req = i_req & w_upper_mask;
  assign o_any       = |i_req;

  // Lowest-index winner among the upper requests, else wrap to the full set.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_src = (|w_upper_req) ? w_upper_req : i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter
// Purpose  : Per-output-port wormhole scheduler. Locks the port to one input
//            from head to tail, pops that FIFO and registers the flit out.
//            Packet-level round-robin fairness across inputs.
// Revision : 1.0 - initial release
// ============================================================================
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int PORT_ID     = 0,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [NUM_IN-1:0]      fifo_empty,
  input  pkt_flit_t [NUM_IN-1:0] fifo_head,
  input  logic                   out_ready,
  output logic [NUM_IN-1:0]      read,
  output logic [NUM_IN-1:0]      grant,
  output pkt_flit_t              out_flit,
  output logic                   busy,
  output logic                   err_orphan,
  output logic                   err_pkt_len
);

  localparam int c_IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int c_CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_PKT_LEN);
  localparam logic [PORT_W-1:0]  c_PORT    = PORT_W'(PORT_ID);

  arb_state_e           r_state,  w_state_nxt;
  logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [c_IDX_W-1:0]   r_owner,  w_owner_nxt;
  logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [NUM_IN-1:0]    r_grant,  w_grant_nxt;
  pkt_flit_t            r_out_flit;
  logic                 r_err_orphan, w_orphan_nxt;
  logic                 r_err_pkt_len, w_len_nxt;

  logic [NUM_IN-1:0]    w_req;
  logic [NUM_IN-1:0]    w_pick_gnt;
  logic [c_IDX_W-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic [NUM_IN-1:0]    w_sel_onehot;
  pkt_flit_t            w_sel_flit;
  logic [NUM_IN-1:0]    w_read;
  logic                 w_fwd;
  logic [c_CNT_W-1:0]   w_cnt_inc;

  // An input requests when its FWFT head is a valid flit for this port.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_req
    assign w_req[gi] = !fifo_empty[gi] && fifo_head[gi].valid &&
                       (fifo_head[gi].output_port_num == c_PORT);
  end

  rr_pick #(
    .N     (NUM_IN),
    .IDX_W (c_IDX_W)
  ) u_rr_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // While locked only the owner is considered; otherwise the picker's winner.
  assign w_sel_onehot = (r_state == ARB_IDLE) ? w_pick_gnt : r_grant;
  assign w_cnt_inc    = r_cnt + c_CNT_W'(1);

  // Mux the head flit of the selected input.
  always_comb begin
    w_sel_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_sel_onehot[i]) w_sel_flit = fifo_head[i];
    end
  end

  // Next-state, pop and forward decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_grant;
    w_read       = '0;
    w_fwd        = 1'b0;
    w_orphan_nxt = 1'b0;
    w_len_nxt    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any && out_ready) begin
          w_read = w_pick_gnt;
          if (w_sel_flit.head) begin
            w_fwd     = 1'b1;
            w_cnt_nxt = c_CNT_W'(1);
            // A single-flit packet completes on the spot: no lock is taken.
            if (w_sel_flit.tail || (MAX_PKT_LEN <= 1)) begin
              w_rr_nxt  = c_IDX_W'(next_rr_ptr(32'(w_pick_idx), 32'(NUM_IN)));
              w_len_nxt = !w_sel_flit.tail;
            end else begin
              w_state_nxt = ARB_LOCKED;
              w_grant_nxt = w_pick_gnt;
              w_owner_nxt = w_pick_idx;
            end
          end else begin
            // Body/tail without an open packet: discard it.
            w_orphan_nxt = 1'b1;
          end
        end
      end
      ARB_LOCKED: begin
        // Owner empty or downstream stalled: hold the lock, counter frozen.
        if ((|(w_req & r_grant)) && out_ready) begin
          w_read    = r_grant;
          w_fwd     = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_sel_flit.tail || (w_cnt_inc == c_CNT_MAX)) begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
            w_rr_nxt    = c_IDX_W'(next_rr_ptr(32'(r_owner), 32'(NUM_IN)));
            w_len_nxt   = !w_sel_flit.tail;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state       <= ARB_IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_out_flit    <= '0;
      r_err_orphan  <= 1'b0;
      r_err_pkt_len <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_owner       <= w_owner_nxt;
      r_cnt         <= w_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_out_flit    <= w_fwd ? w_sel_flit : '0;
      r_err_orphan  <= w_orphan_nxt;
      r_err_pkt_len <= w_len_nxt;
    end
  end

  // Pops are suppressed while reset is held so no flit is lost in reset.
  assign read        = rst_b ? '0 : w_read;
  assign grant       = r_grant;
  assign busy        = (r_state == ARB_LOCKED);
  assign out_flit    = r_out_flit;
  assign err_orphan  = r_err_orphan;
  assign err_pkt_len = r_err_pkt_len;

endmodule
`default_nettype wire

// File: tb/tb_router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_out_arbiter
// Purpose  : Self-checking bench for router_out_arbiter (NUM_IN=2, PORT_ID=0,
//            MAX_PKT_LEN=4). FIFOs are modelled with queues; expected flits
//            go into a scoreboard queue and are matched as they leave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_out_arbiter;
  import router_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  g;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [1:0]      fifo_empty;
  pkt_flit_t [1:0] fifo_head;
  logic            out_ready;
  logic [1:0]      read;
  logic [1:0]      grant;
  pkt_flit_t       out_flit;
  logic            busy;
  logic            err_orphan;
  logic            err_pkt_len;

  pkt_flit_t   q0[$];
  pkt_flit_t   q1[$];
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_valid, first_v, last_v, n_orph, n_len;
  logic [31:0] len_data;

  always #5 clk = ~clk;

  router_out_arbiter #(
    .NUM_IN      (2),
    .PORT_ID     (0),
    .MAX_PKT_LEN (4)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .fifo_empty  (fifo_empty),
    .fifo_head   (fifo_head),
    .out_ready   (out_ready),
    .read        (read),
    .grant       (grant),
    .out_flit    (out_flit),
    .busy        (busy),
    .err_orphan  (err_orphan),
    .err_pkt_len (err_pkt_len)
  );

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic drive_fifos();
    fifo_empty[0] = (q0.size() == 0);
    fifo_empty[1] = (q1.size() == 0);
    fifo_head[0]  = '0;
    fifo_head[1]  = '0;
    if (q0.size() != 0) fifo_head[0] = q0[0];
    if (q1.size() != 0) fifo_head[1] = q1[0];
  endtask

  task automatic push_flit(input int port, input logic h, input logic t, input logic [31:0] d);
    pkt_flit_t f;
    f = '0;
    f.head = h;
    f.tail = t;
    f.valid = 1'b1;
    f.data = d;
    f.output_port_num = '0;
    f.txn_id = d[TXN_W-1:0];
    if (port == 0) q0.push_back(f);
    else q1.push_back(f);
  endtask

  task automatic send_pkt(input int port, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) push_flit(port, (k == 0), (k == n - 1), base + 32'(k));
  endtask

  task automatic exp_push(input logic [31:0] d, input logic [1:0] g);
    exp_t e;
    e.data = d;
    e.g = g;
    exp_q.push_back(e);
  endtask

  // The tail is shown after the lock has dropped, so its expected grant is 0.
  task automatic expect_pkt(input logic [31:0] base, input int n, input logic [1:0] g);
    for (int k = 0; k < n; k++) exp_push(base + 32'(k), (k == n - 1) ? 2'b00 : g);
  endtask

  task automatic clr_stats();
    n_valid = 0;
    first_v = -1;
    last_v = -1;
    n_orph = 0;
    n_len = 0;
    len_data = '0;
  endtask

  // One clock: sample at negedge, apply FIFO pops just after the posedge.
  task automatic step();
    logic [1:0] rd;
    exp_t e;
    drive_fifos();
    @(negedge clk);
    rd = read;
    chk_val("read_onehot", 64'($countones(rd) <= 1), 64'd1);
    if (!out_ready || rst_b) chk_val("read_quiet", 64'(rd), 64'd0);
    if (out_flit.valid) begin
      n_valid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      chk_val("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_val("flit_data", 64'(out_flit.data), 64'(e.data));
        chk_val("flit_grant", 64'(grant), 64'(e.g));
        chk_val("flit_busy", 64'(busy), 64'(|e.g));
      end
    end
    if (err_orphan) n_orph++;
    if (err_pkt_len) begin
      n_len++;
      len_data = out_flit.data;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd[0] && q0.size() > 0) q0.delete(0);
    if (rd[1] && q1.size() > 0) q1.delete(0);
    drive_fifos();
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    step();
    step();
    chk_val("drain_in_budget", 64'(k < budget), 64'd1);
    chk_val("sb_leftover", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k;
    rst_b = 1'b1;
    out_ready = 1'b1;
    drive_fifos();
    clr_stats();
    step();
    step();
    chk_val("rst_grant", 64'(grant), 64'd0);
    chk_val("rst_busy", 64'(busy), 64'd0);
    chk_val("rst_out_flit", 64'(out_flit), 64'd0);
    chk_val("rst_err", 64'({err_orphan, err_pkt_len}), 64'd0);
    rst_b = 1'b0;

    // Contention with rr_ptr=0: in0 first, in1 back-to-back.
    clr_stats();
    send_pkt(0, 1, 4);
    send_pkt(1, 5, 4);
    expect_pkt(1, 4, 2'b01);
    expect_pkt(5, 4, 2'b10);
    drain(40);
    chk_val("cont_count", 64'(n_valid), 64'd8);
    chk_val("cont_no_bubble", 64'(last_v - first_v + 1), 64'd8);
    chk_val("cont_orphan", 64'(n_orph), 64'd0);

    // Next contention: pointer back at in0.
    send_pkt(0, 11, 2);
    send_pkt(1, 13, 2);
    expect_pkt(11, 2, 2'b01);
    expect_pkt(13, 2, 2'b10);
    drain(30);

    // Single packet from in0; pointer moves to in1.
    clr_stats();
    send_pkt(0, 1, 4);
    expect_pkt(1, 4, 2'b01);
    drain(30);
    chk_val("single_count", 64'(n_valid), 64'd4);
    chk_val("single_errs", 64'(n_orph + n_len), 64'd0);

    // Contention now won by in1.
    send_pkt(0, 15, 2);
    send_pkt(1, 17, 2);
    expect_pkt(17, 2, 2'b10);
    expect_pkt(15, 2, 2'b01);
    drain(30);

    // Backpressure for 3 cycles after the 2nd flit is popped.
    clr_stats();
    send_pkt(0, 21, 4);
    expect_pkt(21, 4, 2'b01);
    for (k = 0; k < 10 && q0.size() > 2; k++) step();
    chk_val("bp_reach", 64'(q0.size()), 64'd2);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_val("bp_valid", 64'(out_flit.valid), 64'd0);
      chk_val("bp_grant", 64'(grant), 64'd1);
      chk_val("bp_busy", 64'(busy), 64'd1);
      chk_val("bp_no_pop", 64'(q0.size()), 64'd2);
    end
    out_ready = 1'b1;
    drain(30);
    chk_val("bp_count", 64'(n_valid), 64'd4);

    // Orphan body flit on in1 while idle.
    clr_stats();
    push_flit(1, 1'b0, 1'b0, 9);
    drain(10);
    chk_val("orph_pulse", 64'(n_orph), 64'd1);
    chk_val("orph_no_fwd", 64'(n_valid), 64'd0);

    // Pointer untouched by the orphan: in1 still first.
    send_pkt(0, 31, 2);
    send_pkt(1, 33, 2);
    expect_pkt(33, 2, 2'b10);
    expect_pkt(31, 2, 2'b01);
    drain(30);

    // Runaway: head + 5 bodies, forced release after the 4th flit; the two
    // leftover bodies are dropped as orphans.
    clr_stats();
    push_flit(0, 1'b1, 1'b0, 41);
    for (int d = 42; d <= 46; d++) push_flit(0, 1'b0, 1'b0, 32'(d));
    exp_push(41, 2'b01);
    exp_push(42, 2'b01);
    exp_push(43, 2'b01);
    exp_push(44, 2'b00);
    drain(30);
    chk_val("run_count", 64'(n_valid), 64'd4);
    chk_val("run_len_pulse", 64'(n_len), 64'd1);
    chk_val("run_len_flit", 64'(len_data), 64'd44);
    chk_val("run_orphans", 64'(n_orph), 64'd2);

    // Reset mid-packet after the 2nd flit is popped.
    clr_stats();
    send_pkt(0, 51, 4);
    exp_push(51, 2'b01);
    for (k = 0; k < 10 && q0.size() > 2; k++) step();
    chk_val("rst_reach", 64'(q0.size()), 64'd2);
    rst_b = 1'b1;
    #1;
    chk_val("arst_grant", 64'(grant), 64'd0);
    chk_val("arst_busy", 64'(busy), 64'd0);
    chk_val("arst_out_flit", 64'(out_flit), 64'd0);
    chk_val("arst_read", 64'(read), 64'd0);
    step();
    step();
    rst_b = 1'b0;
    for (k = 0; k < 10 && q0.size() > 0; k++) step();
    step();
    chk_val("rst_drop_done", 64'(q0.size()), 64'd0);
    chk_val("rst_orphans", 64'(n_orph), 64'd2);
    send_pkt(1, 61, 4);
    expect_pkt(61, 4, 2'b10);
    drain(30);
    chk_val("rst_count", 64'(n_valid), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
